// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache between the CPU fetch stage and a
// 128-bit block instruction memory. Misses stall the CPU while one block is filled.
module instruction_cache #(
  parameter int ADDR_WIDTH = 10,
  parameter int INDEX_BITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_read,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  output logic [31:0]           cpu_instruction,
  output logic                  cpu_busywait,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-5:0] mem_address,
  input  logic [127:0]          mem_readdata,
  input  logic                  mem_busywait
);

  localparam int BLK_W = ADDR_WIDTH - 4;
  localparam int TAG_W = BLK_W - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t                  state_r;
  logic                    first_r;
  logic [BLK_W-1:0]        blk_addr_r;
  logic                    mem_read_r;
  logic [BLK_W-1:0]        mem_address_r;
  logic [LINES-1:0]        valid_r;
  logic [TAG_W-1:0]        tag_r  [LINES];
  logic [127:0]            data_r [LINES];

  logic [TAG_W-1:0]        tag_s;
  logic [INDEX_BITS-1:0]   index_s;
  logic [1:0]              offset_s;
  logic [INDEX_BITS-1:0]   fill_index_s;
  logic [TAG_W-1:0]        fill_tag_s;
  logic [127:0]            line_s;
  logic [31:0]             word_s;
  logic                    hit_s;
  logic                    fill_done_s;
  logic                    unused_s;

  assign tag_s        = cpu_address[ADDR_WIDTH-1:INDEX_BITS+4];
  assign index_s      = cpu_address[INDEX_BITS+3:4];
  assign offset_s     = cpu_address[3:2];
  assign unused_s     = ^cpu_address[1:0];
  assign fill_index_s = blk_addr_r[INDEX_BITS-1:0];
  assign fill_tag_s   = blk_addr_r[BLK_W-1:INDEX_BITS];
  assign line_s       = data_r[index_s];

  // The memory only raises busywait after seeing mem_read, so the first MEM_READ edge never completes.
  assign fill_done_s  = (state_r == MEM_READ) && !first_r && !mem_busywait;
  assign hit_s        = cpu_read && valid_r[index_s] && (tag_r[index_s] == tag_s) && (state_r == IDLE);

  // Word select and CPU-facing outputs (zero-cycle hit path)
  always_comb begin
    word_s = 32'h0000_0000;
    case (offset_s)
      2'd0:    word_s = line_s[31:0];
      2'd1:    word_s = line_s[63:32];
      2'd2:    word_s = line_s[95:64];
      2'd3:    word_s = line_s[127:96];
      default: word_s = 32'h0000_0000;
    endcase
    if (hit_s) begin
      cpu_instruction = word_s;
    end else begin
      cpu_instruction = 32'h0000_0000;
    end
    cpu_busywait = (cpu_read && !hit_s) || (state_r != IDLE);
  end

  // Miss-handling FSM with registered memory request and valid bits
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      first_r       <= 1'b0;
      blk_addr_r    <= '0;
      mem_read_r    <= 1'b0;
      mem_address_r <= '0;
      valid_r       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cpu_read && !hit_s) begin
            state_r       <= MEM_READ;
            first_r       <= 1'b1;
            blk_addr_r    <= {tag_s, index_s};
            mem_read_r    <= 1'b1;
            mem_address_r <= {tag_s, index_s};
          end
        end
        MEM_READ: begin
          first_r <= 1'b0;
          if (fill_done_s) begin
            state_r       <= UPDATE;
            mem_read_r    <= 1'b0;
            mem_address_r <= '0;
          end
        end
        UPDATE: begin
          valid_r[fill_index_s] <= 1'b1;
          state_r               <= IDLE;
        end
        default: begin
          state_r       <= IDLE;
          mem_read_r    <= 1'b0;
          mem_address_r <= '0;
        end
      endcase
    end
  end

  // Data and tag storage; contents are qualified by valid_r so they are never cleared
  always_ff @(posedge clock) begin
    if (fill_done_s) begin
      data_r[fill_index_s] <= mem_readdata;
    end
    if (state_r == UPDATE) begin
      tag_r[fill_index_s] <= fill_tag_s;
    end
  end

  assign mem_read    = mem_read_r;
  assign mem_address = mem_address_r;

endmodule
